pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_if.sv | 34 +++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 99 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Controller FSM encoding, the hard-wired zero register, counter width,
// and the per-operand hazard match used by every checked stage.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_INIT  = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  localparam logic [4:0]  GPR_ZERO = 5'd0;
  localparam int unsigned CNT_W    = 32;

  // One source operand against one producing stage; $0 never matches.
  function automatic logic src_hazard(input logic       used,
                                      input logic [4:0] src,
                                      input logic       wen,
                                      input logic [4:0] dst);
    return used && (src != GPR_ZERO) && wen && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle.
// master: datapath side (drives hazard sources, receives stage controls).
// slave : controller side.
interface pipeline_hazard_ctrl_if;
  logic        cpu_en;
  logic        rs_used_id, rt_used_id;
  logic [4:0]  addr_rs_id, addr_rt_id;
  logic        is_branch_id, is_branch_exe, is_branch_mem;
  logic [4:0]  regw_addr_exe, regw_addr_mem, regw_addr_wb;
  logic        wb_wen_exe, wb_wen_mem, wb_wen_wb;
  logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic        if_en, id_en, exe_en, mem_en, wb_en;
  logic [31:0] stall_cnt, flush_cnt;

  modport master (
    output cpu_en, rs_used_id, rt_used_id, addr_rs_id, addr_rt_id,
           is_branch_id, is_branch_exe, is_branch_mem,
           regw_addr_exe, regw_addr_mem, regw_addr_wb,
           wb_wen_exe, wb_wen_mem, wb_wen_wb,
    input  if_rst, id_rst, exe_rst, mem_rst, wb_rst,
           if_en, id_en, exe_en, mem_en, wb_en,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  cpu_en, rs_used_id, rt_used_id, addr_rs_id, addr_rt_id,
           is_branch_id, is_branch_exe, is_branch_mem,
           regw_addr_exe, regw_addr_mem, regw_addr_wb,
           wb_wen_exe, wb_wen_mem, wb_wen_wb,
    output if_rst, id_rst, exe_rst, mem_rst, wb_rst,
           if_en, id_en, exe_en, mem_en, wb_en,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with asynchronous active-high reset.
// Only compiled when HAZARD_PERF_CNT_EN is defined, so the default build
// carries no counter logic at all.
`ifdef HAZARD_PERF_CNT_EN
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Advance on request, hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage pipeline stall/flush controller.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush performance
// counters built from sat_counter); without it both counters read 0.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter bit REGFILE_WR_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  state_e state_q, state_d;
  logic   hz_exe, hz_mem, hz_wb, data_hazard, ctrl_flush, run_active;
  logic [4:0] rst_v, en_v;  // {if, id, exe, mem, wb}
  logic [CNT_W-1:0] stall_cnt_w, flush_cnt_w;

  // Reset sequencing: S_RESET -> S_INIT -> S_RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  // Operand hazards per producing stage; WB only matters without write-first.
  always_comb begin
    hz_exe = src_hazard(hz.rs_used_id, hz.addr_rs_id, hz.wb_wen_exe, hz.regw_addr_exe)
           | src_hazard(hz.rt_used_id, hz.addr_rt_id, hz.wb_wen_exe, hz.regw_addr_exe);
    hz_mem = src_hazard(hz.rs_used_id, hz.addr_rs_id, hz.wb_wen_mem, hz.regw_addr_mem)
           | src_hazard(hz.rt_used_id, hz.addr_rt_id, hz.wb_wen_mem, hz.regw_addr_mem);
    hz_wb  = !REGFILE_WR_FIRST
           && (src_hazard(hz.rs_used_id, hz.addr_rs_id, hz.wb_wen_wb, hz.regw_addr_wb)
             | src_hazard(hz.rt_used_id, hz.addr_rt_id, hz.wb_wen_wb, hz.regw_addr_wb));
    data_hazard = hz_exe | hz_mem | hz_wb;
    ctrl_flush  = hz.is_branch_exe | hz.is_branch_mem;
    run_active  = (state_q == S_RUN) && hz.cpu_en;
  end

  // Stage controls: flush beats stall (ID is wrong-path), then ID branch.
  always_comb begin
    rst_v = 5'b00000;
    en_v  = 5'b11111;
    if (state_q != S_RUN) begin
      rst_v = 5'b11111;
      en_v  = 5'b00000;
    end else if (!hz.cpu_en) begin
      en_v  = 5'b00000;
    end else if (ctrl_flush) begin
      rst_v = 5'b01000;
    end else if (data_hazard) begin
      rst_v = 5'b00100;
      en_v  = 5'b00011;
    end else if (hz.is_branch_id) begin
      rst_v = 5'b01000;
    end
  end

  assign {hz.if_rst, hz.id_rst, hz.exe_rst, hz.mem_rst, hz.wb_rst} = rst_v;
  assign {hz.if_en,  hz.id_en,  hz.exe_en,  hz.mem_en,  hz.wb_en}  = en_v;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc, flush_inc;
  assign stall_inc = run_active && !ctrl_flush && data_hazard;
  assign flush_inc = run_active && (ctrl_flush || (!data_hazard && hz.is_branch_id));

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(stall_inc),
    .cnt_o(stall_cnt_w)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(flush_inc),
    .cnt_o(flush_cnt_w)
  );
`else
  logic unused_run;
  assign unused_run  = run_active;
  assign stall_cnt_w = '0;
  assign flush_cnt_w = '0;
`endif

  assign hz.stall_cnt = stall_cnt_w;
  assign hz.flush_cnt = flush_cnt_w;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (REGFILE_WR_FIRST=1).
// Expected stage controls come from a priority-rule model; counters are
// expected only when HAZARD_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;

  localparam bit WRF = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // {if,id,exe,mem,wb}_rst , {if,id,exe,mem,wb}_en
  localparam logic [9:0] C_RESET  = 10'b11111_00000;
  localparam logic [9:0] C_FREEZE = 10'b00000_00000;
  localparam logic [9:0] C_FLUSH  = 10'b01000_11111;
  localparam logic [9:0] C_STALL  = 10'b00100_00011;
  localparam logic [9:0] C_NORMAL = 10'b00000_11111;

  localparam int SEL_RESET = 0, SEL_FREEZE = 1, SEL_FLUSH = 2,
                 SEL_STALL = 3, SEL_BRID = 4, SEL_NORMAL = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.REGFILE_WR_FIRST(WRF)) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus)
  );

  logic [9:0] obs;
  assign obs = {bus.if_rst, bus.id_rst, bus.exe_rst, bus.mem_rst, bus.wb_rst,
                bus.if_en,  bus.id_en,  bus.exe_en,  bus.mem_en,  bus.wb_en};

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          m_phase  = 0;    // posedges seen since reset release, capped at 2
  logic [31:0] m_stall  = '0;
  logic [31:0] m_flush  = '0;

  // Does any still-visible producer write a register the ID instruction reads?
  function automatic bit model_hazard();
    logic [4:0] dst [3];
    bit         wen [3];
    int         n;
    dst = '{bus.regw_addr_exe, bus.regw_addr_mem, bus.regw_addr_wb};
    wen = '{bus.wb_wen_exe, bus.wb_wen_mem, bus.wb_wen_wb};
    n = WRF ? 2 : 3;
    for (int i = 0; i < n; i++) begin
      if (wen[i] && dst[i] != 5'd0) begin
        if (bus.rs_used_id && bus.addr_rs_id == dst[i]) return 1'b1;
        if (bus.rt_used_id && bus.addr_rt_id == dst[i]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int model_sel();
    if (rst || m_phase < 2)                    return SEL_RESET;
    if (!bus.cpu_en)                           return SEL_FREEZE;
    if (bus.is_branch_exe || bus.is_branch_mem) return SEL_FLUSH;
    if (model_hazard())                        return SEL_STALL;
    if (bus.is_branch_id)                      return SEL_BRID;
    return SEL_NORMAL;
  endfunction

  function automatic logic [9:0] model_ctl(input int s);
    case (s)
      SEL_RESET:  return C_RESET;
      SEL_FREEZE: return C_FREEZE;
      SEL_FLUSH:  return C_FLUSH;
      SEL_STALL:  return C_STALL;
      SEL_BRID:   return C_FLUSH;
      default:    return C_NORMAL;
    endcase
  endfunction

  // Advance one clock and update the reference model alongside the DUT.
  task automatic tick();
    int s;
    s = model_sel();
    @(posedge clk);
    if (!rst) begin
      if (m_phase < 2) m_phase++;
      else if (CNT_EN) begin
        if (s == SEL_STALL && m_stall != '1) m_stall++;
        if ((s == SEL_FLUSH || s == SEL_BRID) && m_flush != '1) m_flush++;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.cpu_en = 1'b1;
    bus.rs_used_id = 1'b0; bus.rt_used_id = 1'b0;
    bus.addr_rs_id = '0;   bus.addr_rt_id = '0;
    bus.is_branch_id = 1'b0; bus.is_branch_exe = 1'b0; bus.is_branch_mem = 1'b0;
    bus.regw_addr_exe = '0; bus.regw_addr_mem = '0; bus.regw_addr_wb = '0;
    bus.wb_wen_exe = 1'b0;  bus.wb_wen_mem = 1'b0;  bus.wb_wen_wb = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 rst = 1'b1;
    m_phase = 0; m_stall = '0; m_flush = '0;
    #1;
    chk_cnt++;
    if (obs !== C_RESET) $display("FAIL reset_ctl: got %b want %b", obs, C_RESET);
    else pass_cnt++;
    chk_cnt++;
    if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0)
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
    else pass_cnt++;
    tick(); tick();
  endtask

  task automatic test_init_sequence();
    int rst_cycles;
    rst = 1'b0;
    rst_cycles = 0;
    #1;
    for (int c = 0; c < 4; c++) begin
      if (obs === C_RESET) rst_cycles++;
      tick();
    end
    chk_cnt++;
    if (rst_cycles != 2) $display("FAIL init_len: got %0d cycles want 2", rst_cycles);
    else pass_cnt++;
    chk_cnt++;
    if (obs !== C_NORMAL) $display("FAIL init_run: got %b want %b", obs, C_NORMAL);
    else pass_cnt++;
  endtask

  task automatic test_data_hazard();
    logic [31:0] base;
    logic [9:0]  want [3];
    base = m_stall;
    want = '{C_STALL, C_STALL, C_NORMAL};
    clear_inputs();
    bus.rs_used_id = 1'b1; bus.addr_rs_id = 5'd3;
    for (int c = 0; c < 3; c++) begin
      bus.wb_wen_exe = (c == 0); bus.regw_addr_exe = (c == 0) ? 5'd3 : 5'd0;
      bus.wb_wen_mem = (c == 1); bus.regw_addr_mem = (c == 1) ? 5'd3 : 5'd0;
      bus.wb_wen_wb  = (c == 2); bus.regw_addr_wb  = (c == 2) ? 5'd3 : 5'd0;
      #1;
      chk_cnt++;
      if (obs !== want[c]) $display("FAIL raw_stall_c%0d: got %b want %b", c, obs, want[c]);
      else pass_cnt++;
      tick();
    end
    chk_cnt++;
    if (bus.stall_cnt !== base + (CNT_EN ? 32'd2 : 32'd0))
      $display("FAIL raw_stall_cnt: got %0d want %0d", bus.stall_cnt, base + (CNT_EN ? 32'd2 : 32'd0));
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    bus.rs_used_id = 1'b1; bus.rt_used_id = 1'b1;
    bus.wb_wen_exe = 1'b1; bus.wb_wen_mem = 1'b1;
    #1;
    chk_cnt++;
    if (obs !== C_NORMAL) $display("FAIL zero_reg: got %b want %b", obs, C_NORMAL);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_branch();
    logic [31:0] base;
    base = m_flush;
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      bus.is_branch_id  = (c == 0);
      bus.is_branch_exe = (c == 1);
      bus.is_branch_mem = (c == 2);
      #1;
      chk_cnt++;
      if (obs !== C_FLUSH) $display("FAIL branch_c%0d: got %b want %b", c, obs, C_FLUSH);
      else pass_cnt++;
      tick();
    end
    clear_inputs();
    #1;
    chk_cnt++;
    if (obs !== C_NORMAL) $display("FAIL branch_after: got %b want %b", obs, C_NORMAL);
    else pass_cnt++;
    chk_cnt++;
    if (bus.flush_cnt !== base + (CNT_EN ? 32'd3 : 32'd0))
      $display("FAIL branch_cnt: got %0d want %0d", bus.flush_cnt, base + (CNT_EN ? 32'd3 : 32'd0));
    else pass_cnt++;
  endtask

  task automatic test_flush_priority();
    logic [31:0] sb, fb;
    sb = m_stall; fb = m_flush;
    clear_inputs();
    bus.rt_used_id = 1'b1; bus.addr_rt_id = 5'd7;
    bus.wb_wen_exe = 1'b1; bus.regw_addr_exe = 5'd7;
    bus.is_branch_mem = 1'b1;
    #1;
    chk_cnt++;
    if (obs !== C_FLUSH) $display("FAIL flush_prio: got %b want %b", obs, C_FLUSH);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus.stall_cnt !== sb || bus.flush_cnt !== fb + (CNT_EN ? 32'd1 : 32'd0))
      $display("FAIL flush_prio_cnt: got %0d/%0d want %0d/%0d", bus.stall_cnt, bus.flush_cnt,
               sb, fb + (CNT_EN ? 32'd1 : 32'd0));
    else pass_cnt++;
  endtask

  task automatic test_freeze();
    logic [31:0] sb, fb;
    sb = m_stall; fb = m_flush;
    clear_inputs();
    bus.cpu_en = 1'b0;
    bus.rs_used_id = 1'b1; bus.addr_rs_id = 5'd5;
    bus.wb_wen_mem = 1'b1; bus.regw_addr_mem = 5'd5;
    bus.is_branch_id = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_cnt++;
      if (obs !== C_FREEZE) $display("FAIL freeze_c%0d: got %b want %b", c, obs, C_FREEZE);
      else pass_cnt++;
      tick();
    end
    chk_cnt++;
    if (bus.stall_cnt !== sb || bus.flush_cnt !== fb)
      $display("FAIL freeze_cnt: got %0d/%0d want %0d/%0d", bus.stall_cnt, bus.flush_cnt, sb, fb);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    bus.rs_used_id = 1'b1; bus.addr_rs_id = 5'd9;
    bus.wb_wen_exe = 1'b1; bus.regw_addr_exe = 5'd9;
    tick();
    #2;
    bus.cpu_en = 1'b0;
    rst = 1'b1;
    m_phase = 0; m_stall = '0; m_flush = '0;
    #1;
    chk_cnt++;
    if (obs !== C_RESET || bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0)
      $display("FAIL mid_stall_rst: got %b %0d/%0d want %b 0/0", obs, bus.stall_cnt, bus.flush_cnt, C_RESET);
    else pass_cnt++;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk_cnt++;
    if (obs !== C_FREEZE || bus.stall_cnt !== 32'd0)
      $display("FAIL post_rst_freeze: got %b %0d want %b 0", obs, bus.stall_cnt, C_FREEZE);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [9:0] want;
    int         errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      bus.cpu_en        = ($urandom_range(0, 9) != 0);
      bus.rs_used_id    = $urandom_range(0, 1);
      bus.rt_used_id    = $urandom_range(0, 1);
      bus.addr_rs_id    = 5'($urandom_range(0, 3));
      bus.addr_rt_id    = 5'($urandom_range(0, 3));
      bus.regw_addr_exe = 5'($urandom_range(0, 3));
      bus.regw_addr_mem = 5'($urandom_range(0, 3));
      bus.regw_addr_wb  = 5'($urandom_range(0, 3));
      bus.wb_wen_exe    = $urandom_range(0, 1);
      bus.wb_wen_mem    = $urandom_range(0, 1);
      bus.wb_wen_wb     = $urandom_range(0, 1);
      bus.is_branch_id  = ($urandom_range(0, 5) == 0);
      bus.is_branch_exe = ($urandom_range(0, 7) == 0);
      bus.is_branch_mem = ($urandom_range(0, 7) == 0);
      #1;
      want = model_ctl(model_sel());
      chk_cnt++;
      if (obs !== want) begin
        if (errs < 10) $display("FAIL rand_ctl_c%0d: got %b want %b", c, obs, want);
        errs++;
      end else pass_cnt++;
      tick();
      chk_cnt++;
      if (bus.stall_cnt !== m_stall || bus.flush_cnt !== m_flush) begin
        if (errs < 10) $display("FAIL rand_cnt_c%0d: got %0d/%0d want %0d/%0d",
                                c, bus.stall_cnt, bus.flush_cnt, m_stall, m_flush);
        errs++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_init_sequence();
    test_data_hazard();
    test_zero_reg();
    test_branch();
    test_flush_priority();
    test_freeze();
    test_random();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
